serial_pattern_generator: RTL and testbench

Synchronous N-bit serial pattern transmitter: accepts an N-bit word and a repeat count over a valid/ready handshake, then shifts the word out MSB-first on a single serial line, once per repetition. It is the transmit-side counterpart of `serial_pattern_detector`. Its `dout` connects directly to the detector's `din`, and the detector sees the pattern after the Nth bit of each word. It is used for link bring-up, sync-word insertion and loopback self-test.

---
 rtl/serial_pattern_generator.sv | 130 +++++++++++++
 tb/tb_serial_pattern_generator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_generator.sv
// Serial pattern transmitter: shifts an N-bit word out MSB-first, s_reps+1 times.
// Optional inter-repetition idle gap enabled by defining SPG_GAP_EN.
module serial_pattern_generator #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1101,
    parameter int             REP_W   = 4,
    parameter int             GAP     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [N-1:0]     s_data,
    input  logic             s_use_default,
    input  logic [REP_W-1:0] s_reps,
    input  logic             abort,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);
    localparam int BW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef SPG_GAP_EN
        , GAP_S
`endif
    } state_t;

    state_t           state;
    logic [N-1:0]     sr;
    logic [REP_W-1:0] rep;
    logic [BW-1:0]    bit_cnt;
    logic [N-1:0]     word;

`ifdef SPG_GAP_EN
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    logic [GW-1:0] gap_cnt;
`endif

    assign word    = s_use_default ? PATTERN : s_data;
    assign s_ready = (state == IDLE);
    assign busy    = (state != IDLE);
    // done marks the final bit of the final repetition; an abort in that cycle wins
    assign done    = (state == SHIFT) && (bit_cnt == '0) && (rep == '0) && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sr         <= '0;
            rep        <= '0;
            bit_cnt    <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
`ifdef SPG_GAP_EN
            gap_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    dout       <= 1'b0;
                    dout_valid <= 1'b0;
                    if (s_valid) begin
                        sr         <= word;
                        rep        <= s_reps;
                        bit_cnt    <= BW'(N - 1);
                        dout       <= word[N-1];
                        dout_valid <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state      <= IDLE;
                        dout       <= 1'b0;
                        dout_valid <= 1'b0;
                    end else begin
                        // dout is registered, so it takes the MSB the rotated sr will hold
                        sr         <= {sr[N-2:0], sr[N-1]};
                        dout       <= sr[N-2];
                        dout_valid <= 1'b1;
                        if (bit_cnt == '0) begin
                            if (rep == '0) begin
                                state      <= IDLE;
                                dout       <= 1'b0;
                                dout_valid <= 1'b0;
                            end else begin
                                rep     <= rep - 1'b1;
                                bit_cnt <= BW'(N - 1);
`ifdef SPG_GAP_EN
                                if (GAP > 0) begin
                                    state      <= GAP_S;
                                    gap_cnt    <= GW'(GAP - 1);
                                    dout       <= 1'b0;
                                    dout_valid <= 1'b0;
                                end
`endif
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
`ifdef SPG_GAP_EN
                GAP_S: begin
                    dout       <= 1'b0;
                    dout_valid <= 1'b0;
                    if (abort) begin
                        state <= IDLE;
                    end else if (gap_cnt == '0) begin
                        // sr has rotated a full word, so it already holds the original MSB
                        state      <= SHIFT;
                        dout       <= sr[N-1];
                        dout_valid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
`endif
                default: begin
                    state      <= IDLE;
                    dout       <= 1'b0;
                    dout_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_pattern_generator.sv
// Bench for serial_pattern_generator: queue-based bit-stream model, directed and random stimulus.
module tb_serial_pattern_generator;
    localparam int N     = 4;
    localparam int REP_W = 4;
    localparam int GAP   = 2;
    localparam logic [N-1:0] PAT = 4'b1101;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_valid = 1'b0, s_ready, s_use_default = 1'b0, abort = 1'b0;
    logic [N-1:0] s_data = '0;
    logic [REP_W-1:0] s_reps = '0;
    logic dout, dout_valid, busy, done;

    serial_pattern_generator #(.N(N), .PATTERN(PAT), .REP_W(REP_W), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_use_default(s_use_default), .s_reps(s_reps),
        .abort(abort), .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic v; logic d; logic dn; } ent_t;
    ent_t q[$];

    int n_vec = 0, n_err = 0;
    logic obs_dout, obs_dv, obs_done, obs_busy, acc_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle stream for one accepted command
    task automatic load(input logic [N-1:0] w, input int reps);
        for (int r = 0; r <= reps; r++) begin
            for (int i = N - 1; i >= 0; i--)
                q.push_back('{v: 1'b1, d: w[i], dn: (r == reps && i == 0)});
`ifdef SPG_GAP_EN
            if (r < reps)
                for (int g = 0; g < GAP; g++) q.push_back('0);
`endif
        end
    endtask

    // Called just after a negedge with inputs already driven for this cycle
    task automatic step();
        ent_t e;
        logic bm;
        #1;
        bm = (q.size() != 0);
        e = bm ? q[0] : '0;
        if (abort && bm) e.dn = 1'b0;
        obs_dout = dout; obs_dv = dout_valid; obs_done = done; obs_busy = busy;
        chk("dout", 32'(dout), 32'(e.d));
        chk("dout_valid", 32'(dout_valid), 32'(e.v));
        chk("done", 32'(done), 32'(e.dn));
        chk("busy", 32'(busy), 32'(bm));
        chk("s_ready", 32'(s_ready), 32'(!bm));
        acc_m = !bm && s_valid;
        if (bm) begin
            if (abort) q.delete();
            else void'(q.pop_front());
        end else if (s_valid) begin
            load(s_use_default ? PAT : s_data, int'(s_reps));
        end
        @(negedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) step();
        chk("drain_timeout", 32'(q.size()), 32'd0);
        step();
    endtask

    task automatic cmd(input logic [N-1:0] d, input logic def, input int reps);
        s_valid = 1'b1; s_data = d; s_use_default = def; s_reps = REP_W'(reps);
    endtask

    logic [15:0] bits, vbits;
    int dcnt, bcnt, done_at, acc_at;
    logic pend;

    initial begin
        // reset state
        #12;
        chk("rst_dout", 32'(dout), 0);
        chk("rst_dout_valid", 32'(dout_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_s_ready", 32'(s_ready), 1);
        @(negedge clk); #1; rst_n = 1'b1;
        @(negedge clk); #1;
        step();

        // default pattern, single shot
        cmd(4'b0000, 1'b1, 0);
        step();
        s_valid = 1'b0;
        bits = '0; dcnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            bits = {bits[14:0], obs_dout};
            if (obs_done) begin dcnt++; done_at = i; end
        end
        chk("default_bits", 32'(bits[3:0]), 32'b1101);
        chk("default_done_cnt", dcnt, 1);
        chk("default_done_at", done_at, 3);
        step();
        chk("default_idle_after", 32'(obs_dv), 0);

`ifndef SPG_GAP_EN
        // repeats back-to-back
        cmd(4'b1001, 1'b0, 2);
        step();
        s_valid = 1'b0;
        bits = '0; dcnt = 0; bcnt = 0; done_at = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            bits = {bits[14:0], obs_dout};
            if (obs_done) begin dcnt++; done_at = i; end
            if (obs_busy) bcnt++;
        end
        chk("repeat_bits", 32'(bits[11:0]), 32'b100110011001);
        chk("repeat_done_cnt", dcnt, 1);
        chk("repeat_done_at", done_at, 11);
        chk("repeat_busy_cycles", bcnt, 12);
        step();
`else
        // repeats separated by gap cycles
        cmd(4'b1001, 1'b0, 1);
        step();
        s_valid = 1'b0;
        bits = '0; vbits = '0; dcnt = 0; done_at = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            bits = {bits[14:0], obs_dout};
            vbits = {vbits[14:0], obs_dv};
            if (obs_done) begin dcnt++; done_at = i; end
        end
        chk("gap_bits", 32'(bits[9:0]), 32'b1001001001);
        chk("gap_valid", 32'(vbits[9:0]), 32'b1111001111);
        chk("gap_done_cnt", dcnt, 1);
        chk("gap_done_at", done_at, 9);
        step();
`endif

        // abort on second bit, then immediate re-accept
        cmd(4'b1001, 1'b0, 0);
        step();
        s_valid = 1'b0;
        step();
        abort = 1'b1;
        step();
        chk("abort_no_done", 32'(obs_done), 0);
        abort = 1'b0;
        cmd(4'b0111, 1'b0, 0);
        step();
        chk("abort_idle_dv", 32'(obs_dv), 0);
        chk("abort_reaccept", 32'(acc_m), 1);
        s_valid = 1'b0;
        step();
        chk("abort_new_first_bit", 32'({obs_dv, obs_dout}), 32'b10);
        drain();

        // back-pressure: second command held until the cycle after done
        cmd(4'b0000, 1'b1, 0);
        step();
        cmd(4'b0110, 1'b0, 0);
        done_at = -1; acc_at = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (obs_done) done_at = i;
            if (acc_m) begin acc_at = i; s_valid = 1'b0; break; end
        end
        chk("bp_done_at", done_at, 3);
        chk("bp_accept_at", acc_at, 4);
        step();
        chk("bp_first_bit", 32'({obs_dv, obs_dout}), 32'b10);
        drain();

        // asynchronous reset mid-word
        cmd(4'b1111, 1'b0, 3);
        step();
        s_valid = 1'b0;
        step(); step();
        rst_n = 1'b0;
        #2;
        chk("arst_dout", 32'(dout), 0);
        chk("arst_dout_valid", 32'(dout_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_s_ready", 32'(s_ready), 1);
        q.delete();
        @(negedge clk); #1; rst_n = 1'b1;
        step();

        // randomized traffic
        pend = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!pend && $urandom_range(0, 3) == 0) begin
                pend = 1'b1;
                s_data = N'($urandom);
                s_use_default = 1'($urandom);
                s_reps = ($urandom_range(0, 9) == 0) ? '1 : REP_W'($urandom_range(0, 2));
            end else if (!pend) begin
                s_data = N'($urandom);
                s_reps = REP_W'($urandom);
            end
            s_valid = pend;
            abort = ($urandom_range(0, 39) == 0);
            step();
            if (acc_m) pend = 1'b0;
        end
        s_valid = 1'b0; abort = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
